// File: rtl/regfile_cycle_unit.sv
// regfile_cycle_unit: picoMIPS instruction-cycle sequencer plus 8 x 8-bit
// register file with switch-mapped read addresses and an LED output register.

// One-hot instruction sequencer: FETCH -> DECODE1 -> DECODE2 -> EXECUTE.
module cycle (
  input  logic       clk,
  input  logic       n_reset,
  output logic [3:0] o_cycle
);
  logic [3:0] r_cycle;

  // Rotate the one-hot token one position per clock; reset parks it in FETCH.
  always_ff @(posedge clk) begin
    if (!n_reset) r_cycle <= 4'b0001;
    else          r_cycle <= {r_cycle[2:0], r_cycle[3]};
  end

  assign o_cycle = r_cycle;
endmodule

// Register storage with two combinational read ports and one write port.
// Addresses 5 and 6 are backed by storage but reads return the switches.
module regs (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_we,
  input  logic [2:0] i_reg1_addr,
  input  logic [2:0] i_reg2_addr,
  input  logic [2:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [8:0] i_switches,
  output logic [7:0] o_reg_1,
  output logic [7:0] o_reg_2,
  output logic [7:0] o_leds
);
  logic [7:0] mem [0:7];
  logic [7:0] r_leds;
  logic       w_commit;

  // A reset edge that coincides with EXECUTE discards the pending write.
  assign w_commit = i_we & n_reset;

  // Storage is deliberately not reset; software initialises it.
  always_ff @(posedge clk) begin
    if (w_commit) mem[i_wr_addr] <= i_wr_data;
  end

  // LED register mirrors writes to address 7.
  always_ff @(posedge clk) begin
    if (!n_reset)                            r_leds <= 8'h00;
    else if (w_commit && i_wr_addr == 3'd7)  r_leds <= i_wr_data;
  end

  // Read port 1: switch addresses bypass storage, no write forwarding.
  always_comb begin
    o_reg_1 = mem[i_reg1_addr];
    if (i_reg1_addr == 3'd5)      o_reg_1 = i_switches[7:0];
    else if (i_reg1_addr == 3'd6) o_reg_1 = {7'b0, i_switches[8]};
  end

  // Read port 2: identical decode to port 1.
  always_comb begin
    o_reg_2 = mem[i_reg2_addr];
    if (i_reg2_addr == 3'd5)      o_reg_2 = i_switches[7:0];
    else if (i_reg2_addr == 3'd6) o_reg_2 = {7'b0, i_switches[8]};
  end

  assign o_leds = r_leds;
endmodule

// Top level: sequencer drives the write strobe of the register file.
module regfile_cycle_unit (
  input  logic       clk,
  input  logic       n_reset,
  output logic [3:0] cycle,
  input  logic [2:0] reg1_addr,
  input  logic [2:0] reg2_addr,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [8:0] switches,
  output logic [7:0] reg_1,
  output logic [7:0] reg_2,
  output logic [7:0] leds
);
  logic [3:0] w_cycle;
  logic       w_we;

  cycle cycle0 (
    .clk     (clk),
    .n_reset (n_reset),
    .o_cycle (w_cycle)
  );

  // Write commits at the edge that ends EXECUTE.
  assign w_we  = w_cycle[3];
  assign cycle = w_cycle;

  regs mem0 (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_we        (w_we),
    .i_reg1_addr (reg1_addr),
    .i_reg2_addr (reg2_addr),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_switches  (switches),
    .o_reg_1     (reg_1),
    .o_reg_2     (reg_2),
    .o_leds      (leds)
  );
endmodule

// File: tb/tb_regfile_cycle_unit.sv
// Directed bench for regfile_cycle_unit with an instruction-level model.
module tb_regfile_cycle_unit;
  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] cycle;
  logic [2:0] reg1_addr, reg2_addr, wr_addr;
  logic [7:0] wr_data;
  logic [8:0] switches;
  logic [7:0] reg_1, reg_2, leds;

  int vectors = 0;
  int miscompares = 0;

  regfile_cycle_unit dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cycle     (cycle),
    .reg1_addr (reg1_addr),
    .reg2_addr (reg2_addr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .switches  (switches),
    .reg_1     (reg_1),
    .reg_2     (reg_2),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  // Model: phase number 0..3, storage contents, which entries are defined.
  int         m_phase = 0;
  logic [7:0] m_mem [8];
  bit         m_known [8];
  logic [7:0] m_leds = 8'h00;
  bit         chk_en = 1'b0;

  initial for (int i = 0; i < 8; i++) m_known[i] = 1'b0;

  always @(posedge clk) begin
    if (n_reset !== 1'b1) begin
      m_phase = 0;
      m_leds  = 8'h00;
    end else begin
      if (m_phase == 3) begin
        m_mem[wr_addr]   = wr_data;
        m_known[wr_addr] = 1'b1;
        if (wr_addr == 3'd7) m_leds = wr_data;
      end
      m_phase = (m_phase + 1) % 4;
    end
  end

  function automatic logic [7:0] exp_rd(logic [2:0] a);
    if (a == 3'd5)      return switches[7:0];
    else if (a == 3'd6) return {7'b0, switches[8]};
    else                return m_mem[a];
  endfunction

  function automatic bit rd_known(logic [2:0] a);
    return (a == 3'd5) || (a == 3'd6) || m_known[a];
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] one;
    logic [3:0] exp_cyc;
    if (chk_en) begin
      one     = 4'b0001;
      exp_cyc = one << m_phase;
      vectors++;
      if (cycle !== exp_cyc) begin
        miscompares++;
        $display("FAIL model_cycle: got %b expected %b", cycle, exp_cyc);
      end
      vectors++;
      if (leds !== m_leds) begin
        miscompares++;
        $display("FAIL model_leds: got %h expected %h", leds, m_leds);
      end
      if (rd_known(reg1_addr)) begin
        vectors++;
        if (reg_1 !== exp_rd(reg1_addr)) begin
          miscompares++;
          $display("FAIL model_reg_1 addr %0d: got %h expected %h", reg1_addr, reg_1, exp_rd(reg1_addr));
        end
      end
      if (rd_known(reg2_addr)) begin
        vectors++;
        if (reg_2 !== exp_rd(reg2_addr)) begin
          miscompares++;
          $display("FAIL model_reg_2 addr %0d: got %h expected %h", reg2_addr, reg_2, exp_rd(reg2_addr));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_fetch();
    int n = 0;
    while (m_phase != 0 && n < 8) begin
      tick();
      n++;
    end
    if (m_phase != 0) chk("wait_fetch", 8'(m_phase), 8'd0);
  endtask

  // Present an instruction in FETCH and return positioned in EXECUTE.
  task automatic issue(input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] wa, input logic [7:0] wd);
    to_fetch();
    reg1_addr = r1;
    reg2_addr = r2;
    wr_addr   = wa;
    wr_data   = wd;
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_reset   = 1'b0;
    reg1_addr = 3'd5;
    reg2_addr = 3'd6;
    wr_addr   = 3'd0;
    wr_data   = 8'h00;
    switches  = 9'h000;

    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_cycle", {4'b0, cycle}, 8'h01);
    chk("reset_leds", leds, 8'h00);

    n_reset = 1'b1;
    tick();
    chk("run_cycle_d1", {4'b0, cycle}, 8'h02);
    tick();
    chk("run_cycle_d2", {4'b0, cycle}, 8'h04);
    tick();
    chk("run_cycle_ex", {4'b0, cycle}, 8'h08);
    tick();
    chk("run_cycle_fetch", {4'b0, cycle}, 8'h01);
    chk("run_leds", leds, 8'h00);

    // Initialise R1, R2 and Z through ordinary writes.
    issue(3'd5, 3'd6, 3'd1, 8'h3C); tick();
    issue(3'd5, 3'd6, 3'd2, 8'h81); tick();
    issue(3'd5, 3'd6, 3'd0, 8'h00); tick();

    // Basic read/write with read-during-write returning the old value.
    issue(3'd1, 3'd2, 3'd1, 8'hA5);
    chk("rw_exec_reg_1", reg_1, 8'h3C);
    chk("rw_exec_reg_2", reg_2, 8'h81);
    tick();
    chk("rw_fetch_reg_1", reg_1, 8'hA5);
    chk("rw_fetch_mem1", dut.mem0.mem[1], 8'hA5);

    // Switch reads alongside a write to R3.
    switches = 9'h15A;
    issue(3'd5, 3'd6, 3'd3, 8'h77);
    chk("sw07", reg_1, 8'h5A);
    chk("sw8_set", reg_2, 8'h01);
    tick();
    switches = 9'h05A;
    #1;
    chk("sw8_clr", reg_2, 8'h00);
    chk("r3_mem", dut.mem0.mem[3], 8'h77);

    // Z register is ordinary storage.
    issue(3'd0, 3'd7, 3'd0, 8'h42);
    chk("z_exec", reg_1, 8'h00);
    tick();
    chk("z_fetch", reg_1, 8'h42);

    // LED load and hold.
    issue(3'd3, 3'd4, 3'd7, 8'hC3);
    chk("led_before", leds, 8'h00);
    tick();
    chk("led_load", leds, 8'hC3);
    chk("led_mem7", dut.mem0.mem[7], 8'hC3);
    issue(3'd7, 3'd1, 3'd4, 8'h11);
    tick();
    chk("led_hold", leds, 8'hC3);
    chk("r4_mem", dut.mem0.mem[4], 8'h11);

    // Write to a switch address lands in storage but stays hidden.
    issue(3'd5, 3'd4, 3'd5, 8'h99);
    tick();
    chk("sw_addr_hidden", reg_1, 8'h5A);
    chk("sw_addr_mem5", dut.mem0.mem[5], 8'h99);

    // Reset in DECODE2 discards the write to R2 and clears the LEDs.
    to_fetch();
    reg1_addr = 3'd2;
    reg2_addr = 3'd7;
    wr_addr   = 3'd2;
    wr_data   = 8'hFF;
    tick();
    tick();
    chk("mid_d2_cycle", {4'b0, cycle}, 8'h04);
    n_reset = 1'b0;
    tick();
    chk("mid_reset_cycle", {4'b0, cycle}, 8'h01);
    chk("mid_reset_leds", leds, 8'h00);
    n_reset = 1'b1;
    wr_addr = 3'd4;
    wr_data = 8'h11;
    repeat (4) tick();
    chk("mid_reset_r2", reg_1, 8'h81);
    chk("mid_reset_mem2", dut.mem0.mem[2], 8'h81);
    chk("mid_reset_u", reg_2, 8'hC3);

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
